// File: rtl/ex_muldiv_unit_pkg.sv
// rtl/ex_muldiv_unit_pkg.sv - shared encodings for the EX-stage RV32M multiply/divide unit
package ex_muldiv_unit_pkg;

    // funct3 encodings of the M extension
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Constants shared with the decoder
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic [6:0]  OPC_OP        = 7'b0110011;
    localparam logic [6:0]  FUNCT7_MULDIV = 7'b0000001;

    // funct3[2] separates the divide group from the multiply group
    function automatic logic md_is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_muldiv_step.sv
// rtl/ex_muldiv_unit_muldiv_step.sv - one shift-add (mul) or restoring shift-subtract (div) iteration
module muldiv_step
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_is_div,
    input  logic [XLEN-1:0] i_hi,
    input  logic [XLEN-1:0] i_lo,
    input  logic [XLEN-1:0] i_opnd,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    logic [XLEN-1:0] w_addend;
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shifted;
    logic [XLEN:0]   w_diff;
    logic            w_qbit;

    // Multiply: add the multiplicand when the current multiplier bit is set
    assign w_addend = i_lo[0] ? i_opnd : '0;
    assign w_sum    = {1'b0, i_hi} + {1'b0, w_addend};

    // Divide: shift the next dividend bit into the partial remainder and trial-subtract
    assign w_shifted = {i_hi, i_lo[XLEN-1]};
    assign w_diff    = w_shifted - {1'b0, i_opnd};
    assign w_qbit    = ~w_diff[XLEN];

    // Select the multiply or divide update of the {hi, lo} pair
    always_comb begin
        o_hi = w_sum[XLEN:1];
        o_lo = {w_sum[0], i_lo[XLEN-1:1]};
        if (i_is_div) begin
            o_hi = w_qbit ? w_diff[XLEN-1:0] : w_shifted[XLEN-1:0];
            o_lo = {i_lo[XLEN-2:0], w_qbit};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M mul/div unit with pipeline stall; MULDIV_FAST_MUL_EN selects a single-cycle multiplier
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]     LAST  = CW'(XLEN - 1);
    localparam logic [CW-1:0]     CONE  = CW'(1);
    localparam logic [XLEN-1:0]   ONE   = XLEN'(1);
    localparam logic [2*XLEN-1:0] ONE2  = (2*XLEN)'(1);
    localparam logic [XLEN-1:0]   SMIN  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         r_state, w_state_nxt;
    md_op_e            r_op;
    logic [CW-1:0]     r_count;
    logic [XLEN-1:0]   r_hi, r_lo, r_opnd, r_result;
    logic              r_neg_q, r_neg_r;

    logic              w_go, w_a_signed, w_b_signed, w_sa, w_sb;
    logic [XLEN-1:0]   w_mag_a, w_mag_b;
    logic              w_div0, w_ovf, w_fast, w_early;
    logic [XLEN-1:0]   w_special_res, w_fast_res, w_early_res;
    logic [XLEN-1:0]   w_hi_nxt, w_lo_nxt;
    logic [2*XLEN-1:0] w_prod, w_prod_fix;
    logic [XLEN-1:0]   w_quo, w_rem, w_final;

    assign w_go = (r_state == MD_IDLE) && start_i && !flush_i;

    // Entry decode: which operands are signed, their sign flags and magnitudes
    assign w_a_signed = (op_i == MD_MULH) || (op_i == MD_MULHSU) || (op_i == MD_DIV) || (op_i == MD_REM);
    assign w_b_signed = (op_i == MD_MULH) || (op_i == MD_DIV) || (op_i == MD_REM);
    assign w_sa       = w_a_signed & rs1_i[XLEN-1];
    assign w_sb       = w_b_signed & rs2_i[XLEN-1];
    assign w_mag_a    = w_sa ? (~rs1_i + ONE) : rs1_i;
    assign w_mag_b    = w_sb ? (~rs2_i + ONE) : rs2_i;

    // Divide-by-zero and signed overflow bypass the iteration entirely
    assign w_div0 = md_is_div(op_i) && (rs2_i == '0);
    assign w_ovf  = ((op_i == MD_DIV) || (op_i == MD_REM)) && (rs1_i == SMIN) && (rs2_i == '1);
    assign w_special_res = w_div0 ? (op_i[1] ? rs1_i : '1)
                                  : (op_i[1] ? '0    : rs1_i);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     w_fa, w_fb;
    logic signed [2*XLEN+1:0] w_fprod;
    assign w_fa       = {w_a_signed & rs1_i[XLEN-1], rs1_i};
    assign w_fb       = {w_b_signed & rs2_i[XLEN-1], rs2_i};
    assign w_fprod    = w_fa * w_fb;
    assign w_fast     = ~md_is_div(op_i);
    assign w_fast_res = (op_i == MD_MUL) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
`else
    assign w_fast     = 1'b0;
    assign w_fast_res = '0;
`endif

    assign w_early     = w_div0 || w_ovf || w_fast;
    assign w_early_res = w_fast ? w_fast_res : w_special_res;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .i_is_div (md_is_div(r_op)),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .i_opnd   (r_opnd),
        .o_hi     (w_hi_nxt),
        .o_lo     (w_lo_nxt)
    );

    // Sign fix-up applied to the outcome of the final iteration
    assign w_prod     = {w_hi_nxt, w_lo_nxt};
    assign w_prod_fix = r_neg_q ? (~w_prod + ONE2) : w_prod;
    assign w_quo      = r_neg_q ? (~w_lo_nxt + ONE) : w_lo_nxt;
    assign w_rem      = r_neg_r ? (~w_hi_nxt + ONE) : w_hi_nxt;

    // Pick the result word for the latched op
    always_comb begin
        w_final = w_prod_fix[2*XLEN-1:XLEN];
        case (r_op)
            MD_MUL:          w_final = w_prod_fix[XLEN-1:0];
            MD_DIV, MD_DIVU: w_final = w_quo;
            MD_REM, MD_REMU: w_final = w_rem;
            default:         ;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= MD_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next state; flush overrides everything, DONE never re-launches
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MD_IDLE: if (w_go) w_state_nxt = w_early ? MD_DONE : MD_CALC;
            MD_CALC: if (r_count == LAST) w_state_nxt = MD_DONE;
            MD_DONE: w_state_nxt = MD_IDLE;
            default: w_state_nxt = MD_IDLE;
        endcase
        if (flush_i) w_state_nxt = MD_IDLE;
    end

    // Datapath: latch operands at entry, iterate in CALC, capture the result on the last step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= MD_MUL;
            r_count  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_result <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (w_go) begin
            r_op    <= md_op_e'(op_i);
            r_count <= '0;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_hi    <= '0;
            if (md_is_div(op_i)) begin
                r_opnd <= w_mag_b;
                r_lo   <= w_mag_a;
            end else begin
                r_opnd <= w_mag_a;
                r_lo   <= w_mag_b;
            end
            if (w_early) r_result <= w_early_res;
        end else if (r_state == MD_CALC) begin
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_count <= r_count + CONE;
            if ((r_count == LAST) && !flush_i) r_result <= w_final;
        end
    end

    assign stall_o  = rst_n && (w_go || (r_state == MD_CALC));
    assign busy_o   = (r_state != MD_IDLE);
    assign done_o   = (r_state == MD_DONE);
    assign result_o = r_result;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - randomized self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst_n, start_i, flush_i;
    logic [2:0]  op_i;
    logic [31:0] rs1_i, rs2_i;
    logic        stall_o, busy_o, done_o;
    logic [31:0] result_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    // RV32M result from plain 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    // Number of cycles stall_o is expected high for one op
    function automatic int exp_stalls(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!op[2]) return 1;
`endif
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op with start_i held until the DONE edge has passed; called mid-cycle
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit chain,
                          output logic [31:0] res, output int stalls, output bit got_done, output logic busy_after);
        start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; flush_i = 1'b0;
        #1;
        stalls = 0; got_done = 1'b0; res = '0; busy_after = 1'b1;
        if (stall_o === 1'b1) stalls++;
        for (int c = 0; c < 100 && !got_done; c++) begin
            @(posedge clk); #1;
            if (done_o === 1'b1) begin
                got_done = 1'b1;
                res = result_o;
            end else if (stall_o === 1'b1) begin
                stalls++;
            end
        end
        if (got_done) begin
            @(posedge clk); #1;
            busy_after = busy_o;
        end
        if (!chain) start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b1; op_i = 3'd0; rs1_i = 32'd5; rs2_i = 32'd3; flush_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (busy_o !== 1'b0)   begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        n_vec++; if (done_o !== 1'b0)   begin n_err++; $display("FAIL reset_done got=%b exp=0", done_o); end
        n_vec++; if (stall_o !== 1'b0)  begin n_err++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
        n_vec++; if (result_o !== 32'h0) begin n_err++; $display("FAIL reset_result got=%h exp=0", result_o); end
        @(negedge clk);
        start_i = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multiply();
        logic [2:0]  t_op  [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
        logic [31:0] t_a   [4] = '{32'd7, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] t_b   [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2};
        logic [31:0] t_exp [4] = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] res; int st; bit gd; logic ba;
        for (int i = 0; i < 4; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], 1'b0, res, st, gd, ba);
            n_vec++; if (gd !== 1'b1) begin n_err++; $display("FAIL mul_done[%0d] got=%b exp=1", i, gd); end
            n_vec++; if (res !== t_exp[i]) begin n_err++; $display("FAIL mul_result[%0d] op=%0d got=%h exp=%h", i, t_op[i], res, t_exp[i]); end
            n_vec++; if (st !== exp_stalls(t_op[i], t_a[i], t_b[i])) begin n_err++; $display("FAIL mul_stalls[%0d] got=%0d exp=%0d", i, st, exp_stalls(t_op[i], t_a[i], t_b[i])); end
        end
    endtask

    task automatic test_divide();
        logic [2:0]  t_op  [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] t_a   [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] t_b   [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] t_exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        logic [31:0] res; int st; bit gd; logic ba;
        for (int i = 0; i < 4; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], 1'b0, res, st, gd, ba);
            n_vec++; if (res !== t_exp[i]) begin n_err++; $display("FAIL div_result[%0d] op=%0d got=%h exp=%h", i, t_op[i], res, t_exp[i]); end
            n_vec++; if (st !== XLEN + 1) begin n_err++; $display("FAIL div_stalls[%0d] got=%0d exp=%0d", i, st, XLEN + 1); end
        end
    endtask

    task automatic test_special_cases();
        logic [2:0]  t_op  [4] = '{3'd4, 3'd6, 3'd4, 3'd6};
        logic [31:0] t_a   [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] t_b   [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] t_exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic [31:0] res; int st; bit gd; logic ba;
        for (int i = 0; i < 4; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], 1'b0, res, st, gd, ba);
            n_vec++; if (res !== t_exp[i]) begin n_err++; $display("FAIL special_result[%0d] got=%h exp=%h", i, res, t_exp[i]); end
            n_vec++; if (st !== 1) begin n_err++; $display("FAIL special_stalls[%0d] got=%0d exp=1", i, st); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] a, b, res; int st; bit gd; logic ba;
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd5; rs1_i = 32'hDEAD_BEEF; rs2_i = 32'd3; flush_i = 1'b0;
        @(posedge clk); #1;
        repeat (9) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        #1;
        n_vec++; if (busy_o !== 1'b0)  begin n_err++; $display("FAIL flush_busy got=%b exp=0", busy_o); end
        n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL flush_stall got=%b exp=0", stall_o); end
        n_vec++; if (done_o !== 1'b0)  begin n_err++; $display("FAIL flush_done got=%b exp=0", done_o); end
        @(posedge clk); #1;
        a = $urandom; b = 32'($urandom_range(1, 1000));
        run_op(3'd5, a, b, 1'b0, res, st, gd, ba);
        n_vec++; if (res !== ref_model(3'd5, a, b)) begin n_err++; $display("FAIL flush_restart got=%h exp=%h", res, ref_model(3'd5, a, b)); end
        n_vec++; if (st !== XLEN + 1) begin n_err++; $display("FAIL flush_restart_stalls got=%0d exp=%0d", st, XLEN + 1); end
        start_i = 1'b1; flush_i = 1'b1; op_i = 3'd4;
        #1;
        n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL flush_wins_stall got=%b exp=0", stall_o); end
        @(posedge clk); #1;
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL flush_wins_busy got=%b exp=0", busy_o); end
        start_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic test_reset_mid_calc();
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd4; rs1_i = 32'd1000; rs2_i = 32'd3; flush_i = 1'b0;
        repeat (12) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++; if (busy_o !== 1'b0)    begin n_err++; $display("FAIL rst_mid_busy got=%b exp=0", busy_o); end
        n_vec++; if (stall_o !== 1'b0)   begin n_err++; $display("FAIL rst_mid_stall got=%b exp=0", stall_o); end
        n_vec++; if (done_o !== 1'b0)    begin n_err++; $display("FAIL rst_mid_done got=%b exp=0", done_o); end
        n_vec++; if (result_o !== 32'h0) begin n_err++; $display("FAIL rst_mid_result got=%h exp=0", result_o); end
        @(negedge clk);
        start_i = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, res; int st; bit gd; logic ba;
        a1 = $urandom; b1 = 32'($urandom_range(1, 60000));
        a2 = $urandom; b2 = 32'($urandom_range(1, 60000));
        run_op(3'd5, a1, b1, 1'b1, res, st, gd, ba);
        n_vec++; if (res !== ref_model(3'd5, a1, b1)) begin n_err++; $display("FAIL b2b_first got=%h exp=%h", res, ref_model(3'd5, a1, b1)); end
        n_vec++; if (ba !== 1'b0) begin n_err++; $display("FAIL b2b_no_reexec busy=%b exp=0", ba); end
        run_op(3'd5, a2, b2, 1'b0, res, st, gd, ba);
        n_vec++; if (res !== ref_model(3'd5, a2, b2)) begin n_err++; $display("FAIL b2b_second got=%h exp=%h", res, ref_model(3'd5, a2, b2)); end
        n_vec++; if (st !== XLEN + 1) begin n_err++; $display("FAIL b2b_second_stalls got=%0d exp=%0d", st, XLEN + 1); end
    endtask

    task automatic test_random();
        logic [2:0] op; logic [31:0] a, b, res, exp; int st; bit gd; logic ba;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            exp = ref_model(op, a, b);
            run_op(op, a, b, 1'b0, res, st, gd, ba);
            n_vec++; if (gd !== 1'b1) begin n_err++; $display("FAIL rand_done[%0d] got=%b exp=1", i, gd); end
            n_vec++; if (res !== exp) begin n_err++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, res, exp); end
            n_vec++; if (st !== exp_stalls(op, a, b)) begin n_err++; $display("FAIL rand_stalls[%0d] op=%0d got=%0d exp=%0d", i, op, st, exp_stalls(op, a, b)); end
            if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_special_cases();
        test_flush();
        test_reset_mid_calc();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout vectors=%0d miscompares=%0d", n_vec, n_err);
        $fatal(1, "timeout");
    end

endmodule
